// File: rtl/instr_decoder_if.sv
// Fetch -> decode -> dispatch bundle for instr_decoder.
// The decoder uses the slave modport; the environment driving it uses master.
interface instr_decoder_if #(
    parameter int PC_WIDTH = 12
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [PC_WIDTH-1:0] in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [6:0]          out_opcode;
    logic [2:0]          out_funct3;
    logic [6:0]          out_funct7;
    logic [4:0]          out_rd;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [31:0]         out_imm;
    logic                out_rd_valid;
    logic                out_rs1_valid;
    logic                out_rs2_valid;
    logic                out_imm_valid;
    logic                out_illegal;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid and its payload stay stable until that edge, ready may move freely.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_imm, out_rd_valid, out_rs1_valid,
               out_rs2_valid, out_imm_valid, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_imm, out_rd_valid, out_rs1_valid,
               out_rs2_valid, out_imm_valid, out_illegal
    );
endinterface

// File: rtl/instr_decoder.sv
// RV32I decode stage with a two-entry skid buffer (main M, skid S).
// Define QU_DECODER_ILLEGAL_CHECK_EN to enable illegal-instruction detection.
module instr_decoder #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    instr_decoder_if.slave dec_if,
    output logic [1:0]     o_dbg_state
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic                rd_v;
        logic                rs1_v;
        logic                rs2_v;
        logic                imm_v;
        logic                illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_out_valid;
    entry_t r_m;
    entry_t r_s;
    entry_t w_dec;

    logic [INSTR_WIDTH-1:0] w_instr;
    logic w_in_hs;
    logic w_out_hs;
    logic w_load_m_in;
    logic w_load_m_skid;
    logic w_load_s;

`ifdef QU_DECODER_ILLEGAL_CHECK_EN
    function automatic logic f_illegal(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
        f3  = i[14:12];
        f7  = i[31:25];
        ill = (i[1:0] != 2'b11);
        case (i[6:0])
            OP_OP:     if (!(f7 == 7'h00 || f7 == 7'h20) ||
                           (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5))) ill = 1'b1;
            OP_IMM:    if ((f3 == 3'd1 && f7 != 7'h00) ||
                           (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) ill = 1'b1;
            OP_LOAD:   if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ill = 1'b1;
            OP_STORE:  if (f3 > 3'd2) ill = 1'b1;
            OP_BRANCH: if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            OP_JALR:   if (f3 != 3'd0) ill = 1'b1;
            OP_SYSTEM: if ((f3 == 3'd0 && i[31:20] != 12'd0 && i[31:20] != 12'd1) ||
                           f3 == 3'd4) ill = 1'b1;
            OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE: ;
            default:   ill = 1'b1;
        endcase
        return ill;
    endfunction
`endif

    assign w_instr = dec_if.in_instr;

    // Pure field split plus class-driven immediate and operand-valid flags.
    always_comb begin
        w_dec        = '0;
        w_dec.pc     = dec_if.in_pc;
        w_dec.opcode = w_instr[6:0];
        w_dec.funct3 = w_instr[14:12];
        w_dec.funct7 = w_instr[31:25];
        w_dec.rd     = w_instr[11:7];
        w_dec.rs1    = w_instr[19:15];
        w_dec.rs2    = w_instr[24:20];
        case (w_instr[6:0])
            OP_OP: begin
                w_dec.rd_v  = 1'b1;
                w_dec.rs1_v = 1'b1;
                w_dec.rs2_v = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                w_dec.imm   = {{20{w_instr[31]}}, w_instr[31:20]};
                w_dec.rd_v  = 1'b1;
                w_dec.rs1_v = 1'b1;
                w_dec.imm_v = 1'b1;
            end
            OP_STORE: begin
                w_dec.imm   = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_dec.rs1_v = 1'b1;
                w_dec.rs2_v = 1'b1;
                w_dec.imm_v = 1'b1;
            end
            OP_BRANCH: begin
                w_dec.imm   = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                               w_instr[30:25], w_instr[11:8], 1'b0};
                w_dec.rs1_v = 1'b1;
                w_dec.rs2_v = 1'b1;
                w_dec.imm_v = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_dec.imm   = {w_instr[31:12], 12'b0};
                w_dec.rd_v  = 1'b1;
                w_dec.imm_v = 1'b1;
            end
            OP_JAL: begin
                w_dec.imm   = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                               w_instr[20], w_instr[30:21], 1'b0};
                w_dec.rd_v  = 1'b1;
                w_dec.imm_v = 1'b1;
            end
            OP_SYSTEM: begin
                // funct3==0 is ECALL/EBREAK (no operands); otherwise a CSR op.
                if (w_instr[14:12] != 3'd0) begin
                    w_dec.imm   = {20'b0, w_instr[31:20]};
                    w_dec.rd_v  = 1'b1;
                    w_dec.imm_v = 1'b1;
                    w_dec.rs1_v = ~w_instr[14];
                end
            end
            default: ;
        endcase
`ifdef QU_DECODER_ILLEGAL_CHECK_EN
        w_dec.illegal = f_illegal(w_instr[31:0]);
`else
        w_dec.illegal = 1'b0;
`endif
        if (w_dec.rd == 5'd0) w_dec.rd_v = 1'b0;
        if (w_dec.illegal) begin
            w_dec.rd_v  = 1'b0;
            w_dec.rs1_v = 1'b0;
            w_dec.rs2_v = 1'b0;
            w_dec.imm_v = 1'b0;
        end
    end

    // in_ready looks only at the registered occupancy, never at out_ready.
    assign dec_if.in_ready = !rst && (r_state != ST_TWO);
    assign w_in_hs         = dec_if.in_valid && dec_if.in_ready;
    assign w_out_hs        = r_out_valid && dec_if.out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_m_in   = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_hs) begin
                        w_state_nxt = ST_ONE;
                        w_load_m_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_hs && w_out_hs) begin
                        w_load_m_in = 1'b1;
                    end else if (w_in_hs) begin
                        w_state_nxt = ST_TWO;
                        w_load_s    = 1'b1;
                    end else if (w_out_hs) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_hs) begin
                        w_state_nxt   = ST_ONE;
                        w_load_m_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_m <= '0;
            r_s <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m <= w_dec;
            end else if (w_load_m_skid) begin
                r_m <= r_s;
            end
            if (w_load_s) begin
                r_s <= w_dec;
            end
        end
    end

    assign o_dbg_state          = r_state;
    assign dec_if.out_valid     = r_out_valid;
    assign dec_if.out_pc        = r_m.pc;
    assign dec_if.out_opcode    = r_m.opcode;
    assign dec_if.out_funct3    = r_m.funct3;
    assign dec_if.out_funct7    = r_m.funct7;
    assign dec_if.out_rd        = r_m.rd;
    assign dec_if.out_rs1       = r_m.rs1;
    assign dec_if.out_rs2       = r_m.rs2;
    assign dec_if.out_imm       = r_m.imm;
    assign dec_if.out_rd_valid  = r_m.rd_v;
    assign dec_if.out_rs1_valid = r_m.rs1_v;
    assign dec_if.out_rs2_valid = r_m.rs2_v;
    assign dec_if.out_imm_valid = r_m.imm_v;
    assign dec_if.out_illegal   = r_m.illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: directed steps then random traffic, checked against
// a FIFO-of-decoded-entries reference model built from the RV32I field rules.
module tb_instr_decoder;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] dbg_state;

  instr_decoder_if #(.PC_WIDTH(12)) bus ();

  instr_decoder #(.INSTR_WIDTH(32), .PC_WIDTH(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .dec_if      (bus),
    .o_dbg_state (dbg_state)
  );

  typedef struct packed {
    logic [11:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rd_v;
    logic        rs1_v;
    logic        rs2_v;
    logic        imm_v;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [11:0] pc;
  } pend_t;

  dec_t  exp_q[$];
  pend_t pend_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  logic [11:0] pc_ctr = 12'h200;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  // Reference decode straight from the RV32I encoding rules.
  function automatic dec_t model(input logic [31:0] ins, input logic [11:0] pc);
    dec_t d;
    int   v;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ill;
    f3 = ins[14:12];
    f7 = ins[31:25];
    d = '0;
    d.pc = pc; d.opcode = ins[6:0]; d.funct3 = f3; d.funct7 = f7;
    d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
    case (ins[6:0])
      7'b0110011: begin d.rd_v = 1; d.rs1_v = 1; d.rs2_v = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        d.imm = 32'(sext(int'(ins[31:20]), 12));
        d.rd_v = 1; d.rs1_v = 1; d.imm_v = 1;
      end
      7'b0100011: begin
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        d.imm = 32'(sext(v, 12));
        d.rs1_v = 1; d.rs2_v = 1; d.imm_v = 1;
      end
      7'b1100011: begin
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        d.imm = 32'(sext(v, 13));
        d.rs1_v = 1; d.rs2_v = 1; d.imm_v = 1;
      end
      7'b0110111, 7'b0010111: begin
        d.imm = 32'(int'(ins[31:12]) * 4096);
        d.rd_v = 1; d.imm_v = 1;
      end
      7'b1101111: begin
        v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        d.imm = 32'(sext(v, 21));
        d.rd_v = 1; d.imm_v = 1;
      end
      7'b1110011: begin
        if (f3 != 0) begin
          d.imm = 32'(int'(ins[31:20]));
          d.rd_v = 1; d.imm_v = 1; d.rs1_v = (f3 < 4);
        end
      end
      default: ;
    endcase
    ill = 1'b0;
`ifdef QU_DECODER_ILLEGAL_CHECK_EN
    if (ins[1:0] != 2'b11) ill = 1;
    case (ins[6:0])
      7'b0110011: ill = ill | !(f7 == 0 || f7 == 7'h20) | (f7 == 7'h20 && f3 != 0 && f3 != 5);
      7'b0010011: ill = ill | (f3 == 1 && f7 != 0) | (f3 == 5 && f7 != 0 && f7 != 7'h20);
      7'b0000011: ill = ill | (f3 == 3 || f3 == 6 || f3 == 7);
      7'b0100011: ill = ill | (f3 > 2);
      7'b1100011: ill = ill | (f3 == 2 || f3 == 3);
      7'b1100111: ill = ill | (f3 != 0);
      7'b1110011: ill = ill | (f3 == 4) | (f3 == 0 && ins[31:20] > 1);
      7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111: ;
      default: ill = 1;
    endcase
`endif
    d.illegal = ill;
    if (d.rd == 0) d.rd_v = 0;
    if (ill) begin d.rd_v = 0; d.rs1_v = 0; d.rs2_v = 0; d.imm_v = 0; end
    return d;
  endfunction

  task automatic compare_all();
    chk("in_ready", bus.in_ready, (!rst && exp_q.size() < 2));
    chk("out_valid", bus.out_valid, (exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("out_pc", bus.out_pc, exp_q[0].pc);
      chk("out_opcode", bus.out_opcode, exp_q[0].opcode);
      chk("out_funct3", bus.out_funct3, exp_q[0].funct3);
      chk("out_funct7", bus.out_funct7, exp_q[0].funct7);
      chk("out_regs", {bus.out_rd, bus.out_rs1, bus.out_rs2},
          {exp_q[0].rd, exp_q[0].rs1, exp_q[0].rs2});
      chk("out_imm", bus.out_imm, exp_q[0].imm);
      chk("out_flags", {bus.out_rd_valid, bus.out_rs1_valid, bus.out_rs2_valid, bus.out_imm_valid},
          {exp_q[0].rd_v, exp_q[0].rs1_v, exp_q[0].rs2_v, exp_q[0].imm_v});
      chk("out_illegal", bus.out_illegal, exp_q[0].illegal);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, check at negedge+1.
  task automatic cycle(input bit ordy, input bit fl, input bit rs);
    bit in_hs, out_hs;
    rst           = rs;
    flush         = fl;
    bus.out_ready = ordy;
    bus.in_valid  = (pend_q.size() > 0);
    if (pend_q.size() > 0) begin
      bus.in_instr = pend_q[0].instr;
      bus.in_pc    = pend_q[0].pc;
    end else begin
      bus.in_instr = $urandom();
      bus.in_pc    = 12'($urandom());
    end
    in_hs  = bus.in_valid && !rs && exp_q.size() < 2;
    out_hs = ordy && exp_q.size() > 0;
    @(posedge clk);
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (out_hs) void'(exp_q.pop_front());
      if (in_hs) exp_q.push_back(model(pend_q[0].instr, pend_q[0].pc));
    end
    if (in_hs) void'(pend_q.pop_front());
    @(negedge clk);
    #1;
    compare_all();
  endtask

  task automatic offer(input logic [31:0] ins, input logic [11:0] pc);
    pend_t p;
    p.instr = ins;
    p.pc    = pc;
    pend_q.push_back(p);
  endtask

  logic [6:0] ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                           7'b1110011};

  initial begin
    logic [31:0] ins;
    bit exp_ill;
`ifdef QU_DECODER_ILLEGAL_CHECK_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;

    // Reset
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_outputs_zero", {bus.out_pc, bus.out_imm, bus.out_rd, bus.out_opcode}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // addi x5,x1,-1
    offer(32'hFFF08293, 12'h010);
    cycle(1, 0, 0);
    chk("addi_rd", bus.out_rd, 5);
    chk("addi_rs1", bus.out_rs1, 1);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("addi_flags", {bus.out_rd_valid, bus.out_rs1_valid, bus.out_rs2_valid, bus.out_imm_valid}, 4'b1101);

    // sw x2,8(x3) then beq x1,x2,-4
    offer(32'h0021A423, 12'h014);
    offer(32'hFE208EE3, 12'h018);
    cycle(1, 0, 0);
    chk("sw_fields", {bus.out_rs1, bus.out_rs2, bus.out_funct3}, {5'd3, 5'd2, 3'd2});
    chk("sw_imm", bus.out_imm, 32'd8);
    chk("sw_rd_valid", bus.out_rd_valid, 1'b0);
    cycle(1, 0, 0);
    chk("beq_imm", bus.out_imm, 32'hFFFFFFFC);
    cycle(1, 0, 0);

    // Back-pressure: A,B fill the buffer, C waits
    offer(32'h00100093, 12'h100);
    offer(32'h00200113, 12'h104);
    offer(32'h00300193, 12'h108);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("bp_in_ready_full", bus.in_ready, 1'b0);
    cycle(0, 0, 0);
    chk("bp_hold_pc", bus.out_pc, 12'h100);
    cycle(1, 0, 0);
    chk("bp_second_pc", bus.out_pc, 12'h104);
    cycle(1, 0, 0);
    chk("bp_third_pc", bus.out_pc, 12'h108);
    cycle(1, 0, 0);
    chk("bp_drained", bus.out_valid, 1'b0);

    // Flush with two buffered and a new input offered
    offer(32'h00400213, 12'h200);
    offer(32'h00500293, 12'h204);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    offer(32'h00600313, 12'h208);
    cycle(0, 1, 0);
    pend_q.delete();
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);

    // Flush in ONE with a handshake in the same cycle: input discarded
    offer(32'h00700393, 12'h300);
    cycle(0, 0, 0);
    offer(32'h00800413, 12'h304);
    cycle(1, 1, 0);
    chk("flush1_out_valid", bus.out_valid, 1'b0);
    cycle(1, 0, 0);
    chk("flush1_nothing", bus.out_valid, 1'b0);

    // Illegal candidates and rd=x0
    offer(32'h00000000, 12'h400);
    cycle(1, 0, 0);
    chk("ill_zero", bus.out_illegal, exp_ill);
    offer(32'h40001033, 12'h404);
    cycle(1, 0, 0);
    chk("ill_sll20", bus.out_illegal, exp_ill);
    offer(32'h00208033, 12'h408);
    cycle(1, 0, 0);
    chk("add_x0_rd_valid", bus.out_rd_valid, 1'b0);
    cycle(1, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (pend_q.size() < 2 && $urandom_range(0, 3) != 0) begin
        ins = $urandom();
        if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 10)];
        pc_ctr = pc_ctr + 12'd4;
        offer(ins, pc_ctr);
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, 1'b0);
    end

    // Reset with two entries buffered
    pend_q.delete();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    offer(32'h00900493, 12'h500);
    offer(32'h00A00513, 12'h504);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("rst2_out_valid", bus.out_valid, 1'b0);
    chk("rst2_outputs_zero", {bus.out_pc, bus.out_imm, bus.out_rs1, bus.out_rd_valid, bus.out_imm_valid}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst2_in_ready", bus.in_ready, 1'b1);
    cycle(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
